// File: rtl/seg7_scan_driver_pkg.sv
// seg7 glyph codes and active-low segment patterns.
// Pattern bit order is {g, f, e, d, c, b, a}.
package seg7_pkg;

  typedef enum logic [2:0] {
    SEG_A, SEG_B, SEG_C, SEG_D,
    SEG_E, SEG_F, SEG_G
  } seg_idx_e;

  localparam logic [4:0] G_HEX0  = 5'd0;
  localparam logic [4:0] G_HEX1  = 5'd1;
  localparam logic [4:0] G_HEX2  = 5'd2;
  localparam logic [4:0] G_HEX3  = 5'd3;
  localparam logic [4:0] G_HEX4  = 5'd4;
  localparam logic [4:0] G_HEX5  = 5'd5;
  localparam logic [4:0] G_HEX6  = 5'd6;
  localparam logic [4:0] G_HEX7  = 5'd7;
  localparam logic [4:0] G_HEX8  = 5'd8;
  localparam logic [4:0] G_HEX9  = 5'd9;
  localparam logic [4:0] G_HEXA  = 5'd10;
  localparam logic [4:0] G_HEXB  = 5'd11;
  localparam logic [4:0] G_HEXC  = 5'd12;
  localparam logic [4:0] G_HEXD  = 5'd13;
  localparam logic [4:0] G_HEXE  = 5'd14;
  localparam logic [4:0] G_HEXF  = 5'd15;
  localparam logic [4:0] G_BLANK = 5'd16;
  localparam logic [4:0] G_DASH  = 5'd17;
  localparam logic [4:0] G_B     = 5'd18;
  localparam logic [4:0] G_N     = 5'd19;
  localparam logic [4:0] G_R     = 5'd20;
  localparam logic [4:0] G_O     = 5'd21;
  localparam logic [4:0] G_P     = 5'd22;
  localparam logic [4:0] G_L     = 5'd23;
  localparam logic [4:0] G_H     = 5'd24;

  localparam logic [6:0] S_0     = 7'h40;
  localparam logic [6:0] S_1     = 7'h79;
  localparam logic [6:0] S_2     = 7'h24;
  localparam logic [6:0] S_3     = 7'h30;
  localparam logic [6:0] S_4     = 7'h19;
  localparam logic [6:0] S_5     = 7'h12;
  localparam logic [6:0] S_6     = 7'h02;
  localparam logic [6:0] S_7     = 7'h78;
  localparam logic [6:0] S_8     = 7'h00;
  localparam logic [6:0] S_9     = 7'h10;
  localparam logic [6:0] S_A     = 7'h08;
  localparam logic [6:0] S_LB    = 7'h03;
  localparam logic [6:0] S_C     = 7'h46;
  localparam logic [6:0] S_D     = 7'h21;
  localparam logic [6:0] S_E     = 7'h06;
  localparam logic [6:0] S_F     = 7'h0E;
  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_DASH  = 7'h3F;
  localparam logic [6:0] S_N     = 7'h2B;
  localparam logic [6:0] S_R     = 7'h2F;
  localparam logic [6:0] S_O     = 7'h23;
  localparam logic [6:0] S_P     = 7'h0C;
  localparam logic [6:0] S_L     = 7'h47;
  localparam logic [6:0] S_H     = 7'h09;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Double-buffered load port of the 7-segment scanner.
// Upstream formatters drive master; the scanner takes slave.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [5*NUM_DIGITS-1:0]   glyph;
  logic [NUM_DIGITS-1:0]     dp;
  logic [NUM_DIGITS-1:0]     blink;
  logic [NUM_DIGITS-1:0]     blank;

  modport master (
    output load, glyph, dp, blink, blank
  );

  modport slave (
    input load, glyph, dp, blink, blank
  );
endinterface

// File: rtl/seg7_scan_driver_glyph_rom.sv
// Combinational glyph decoder: 5-bit code to
// active-low {g..a} pattern; unused codes are blank.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pat
);
  always_comb begin
    pat = S_BLANK;
    case (code)
      G_HEX0: pat = S_0;
      G_HEX1: pat = S_1;
      G_HEX2: pat = S_2;
      G_HEX3: pat = S_3;
      G_HEX4: pat = S_4;
      G_HEX5: pat = S_5;
      G_HEX6: pat = S_6;
      G_HEX7: pat = S_7;
      G_HEX8: pat = S_8;
      G_HEX9: pat = S_9;
      G_HEXA: pat = S_A;
      G_HEXB: pat = S_LB;
      G_HEXC: pat = S_C;
      G_HEXD: pat = S_D;
      G_HEXE: pat = S_E;
      G_HEXF: pat = S_F;
      G_DASH: pat = S_DASH;
      G_B:    pat = S_LB;
      G_N:    pat = S_N;
      G_R:    pat = S_R;
      G_O:    pat = S_O;
      G_P:    pat = S_P;
      G_L:    pat = S_L;
      G_H:    pat = S_H;
      default: pat = S_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scanner with
// double-buffered load, dead time and blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 200000,
  parameter int DEAD_CYCLES  = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_driver_if.slave     ld,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int GW = 5 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] ONE = 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  bphase;
  logic                  tick;
  logic                  wrap;
  logic                  dead;

  logic [GW-1:0]         act_glyph;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blink;
  logic [NUM_DIGITS-1:0] act_blank;
  logic [GW-1:0]         pend_glyph;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blink;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_valid;

  logic [4:0]            cur_glyph;
  logic                  cur_dp;
  logic                  cur_off;
  logic [6:0]            cur_pat;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick &&
    (idx == IW'(NUM_DIGITS - 1));

  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign dead = (cnt < CW'(DEAD_CYCLES));
    end else begin : g_no_dead
      assign dead = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt   <= '0;
      bphase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt   <= '0;
        bphase <= ~bphase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // A same-cycle load lands in pending after the
  // frame swap has consumed the older contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_glyph  <= {NUM_DIGITS{G_BLANK}};
      act_dp     <= '0;
      act_blink  <= '0;
      act_blank  <= '0;
      pend_glyph <= {NUM_DIGITS{G_BLANK}};
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (wrap && pend_valid) begin
        act_glyph  <= pend_glyph;
        act_dp     <= pend_dp;
        act_blink  <= pend_blink;
        act_blank  <= pend_blank;
        pend_valid <= 1'b0;
      end
      if (ld.load) begin
        pend_glyph <= ld.glyph;
        pend_dp    <= ld.dp;
        pend_blink <= ld.blink;
        pend_blank <= ld.blank;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_glyph = G_BLANK;
    cur_dp    = 1'b0;
    cur_off   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_glyph = act_glyph[5*i +: 5];
        cur_dp    = act_dp[i];
        cur_off   = act_blank[i] |
                    (act_blink[i] & bphase);
      end
    end
  end

  seg7_glyph_rom u_rom (
    .code (cur_glyph),
    .pat  (cur_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= dead ? '1 : ~(ONE << idx);
      seg        <= cur_off ? 8'hFF
                            : {~cur_dp, cur_pat};
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver
// against a cycle-count reference model.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FR = N * SD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] an;
  logic [7:0]   seg;
  logic         frame_tick;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) ld_if ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (SD),
    .DEAD_CYCLES  (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_if.slave),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Lit segments (active-high, {g..a}) per code 0..24.
  logic [6:0] lit [0:31];
  initial begin
    lit = '{default: 7'h00};
    lit[0]  = 7'h3F; lit[1]  = 7'h06;
    lit[2]  = 7'h5B; lit[3]  = 7'h4F;
    lit[4]  = 7'h66; lit[5]  = 7'h6D;
    lit[6]  = 7'h7D; lit[7]  = 7'h07;
    lit[8]  = 7'h7F; lit[9]  = 7'h6F;
    lit[10] = 7'h77; lit[11] = 7'h7C;
    lit[12] = 7'h39; lit[13] = 7'h5E;
    lit[14] = 7'h79; lit[15] = 7'h71;
    lit[17] = 7'h40; lit[18] = 7'h7C;
    lit[19] = 7'h54; lit[20] = 7'h50;
    lit[21] = 7'h5C; lit[22] = 7'h73;
    lit[23] = 7'h38; lit[24] = 7'h76;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int c = 0;

  logic [4:0] m_ag [N];
  logic [4:0] m_pg [N];
  logic [N-1:0] m_adp, m_abk, m_abl;
  logic [N-1:0] m_pdp, m_pbk, m_pbl;
  bit m_pv;

  logic [N-1:0] e_an;
  logic [7:0]   e_seg;
  logic         e_ft;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, c, got, exp);
    end
  endtask

  task automatic m_reset();
    c = 0;
    m_pv = 0;
    for (int i = 0; i < N; i++) begin
      m_ag[i] = 5'd16;
      m_pg[i] = 5'd16;
    end
    m_adp = '0; m_abk = '0; m_abl = '0;
    m_pdp = '0; m_pbk = '0; m_pbl = '0;
  endtask

  // One clock: predict outputs from the cycle just
  // ended, advance the model, then compare.
  task automatic cyc();
    int slot, pos, frames;
    bit bph, off;
    @(posedge clk);
    if (rst) begin
      m_reset();
      e_an = '1; e_seg = 8'hFF; e_ft = 1'b0;
    end else begin
      pos    = c % SD;
      slot   = (c / SD) % N;
      frames = c / FR;
      bph    = ((frames / BF) % 2) == 1;
      e_an   = (pos < DC) ? '1 : ~(N'(1) << slot);
      off    = m_abl[slot] | (m_abk[slot] & bph);
      e_seg  = off ? 8'hFF :
               {~m_adp[slot], ~lit[m_ag[slot]]};
      e_ft   = (c % FR) == FR - 1;
      if (e_ft && m_pv) begin
        m_ag  = m_pg;
        m_adp = m_pdp; m_abk = m_pbk; m_abl = m_pbl;
        m_pv  = 0;
      end
      if (ld_if.load) begin
        for (int i = 0; i < N; i++)
          m_pg[i] = ld_if.glyph[5*i +: 5];
        m_pdp = ld_if.dp;
        m_pbk = ld_if.blink;
        m_pbl = ld_if.blank;
        m_pv  = 1;
      end
      c++;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [5*N-1:0] g,
                      input logic [N-1:0] d,
                      input logic [N-1:0] bk,
                      input logic [N-1:0] bl);
    ld_if.load  = 1'b1;
    ld_if.glyph = g;
    ld_if.dp    = d;
    ld_if.blink = bk;
    ld_if.blank = bl;
    cyc();
    ld_if.load = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  task automatic until_pos(input int p);
    for (int i = 0; i < FR && (c % FR) != p; i++)
      cyc();
  endtask

  initial begin
    ld_if.load  = 1'b0;
    ld_if.glyph = '0;
    ld_if.dp    = '0;
    ld_if.blink = '0;
    ld_if.blank = '0;
    m_reset();
    // Reset with a load pending in the reset cycle.
    ld_if.load = 1'b1;
    ld_if.glyph = {5'd8, 5'd8, 5'd8, 5'd8};
    do_reset(3);
    ld_if.load = 1'b0;
    run(40);

    // Load {3,2,1,0} at cycle 2 after reset.
    do_reset(2);
    run(2);
    load({5'd3, 5'd2, 5'd1, 5'd0}, '0, '0, '0);
    until_pos(0);
    run(2);
    check("slot0_an", 32'(an), 32'h0000000E);
    check("slot0_seg", 32'(seg), 32'h000000C0);
    run(FR * 2);

    // Load A mid-frame, B on the internal frame wrap.
    until_pos(5);
    load({5'd10, 5'd11, 5'd12, 5'd13}, '0, '0, '0);
    until_pos(FR - 1);
    load({5'd19, 5'd20, 5'd21, 5'd22}, '0, '0, '0);
    run(FR * 3);
    // B again on the cycle frame_tick is visible.
    until_pos(0);
    load({5'd23, 5'd24, 5'd17, 5'd18}, '0, '0, '0);
    run(FR * 3);

    // Blink digit 0 showing a dash.
    load({5'd4, 5'd5, 5'd6, 5'd17}, '0, 4'b0001, '0);
    run(FR * 9);

    // Blank plus decimal point.
    load({5'd7, 5'd9, 5'd15, 5'd14}, 4'b0100,
         '0, 4'b0010);
    run(FR * 2);

    // Mid-slot reset while slot 2 is lit.
    until_pos(5);
    load({5'd1, 5'd1, 5'd1, 5'd1}, '1, '0, '0);
    until_pos(10);
    check("pre_rst_an", 32'(an), 32'h0000000B);
    do_reset(1);
    run(FR * 2);

    // Randomised loads and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      ld_if.load  = ($urandom_range(0, 11) == 0);
      ld_if.glyph = 20'($urandom);
      ld_if.dp    = 4'($urandom);
      ld_if.blink = 4'($urandom);
      ld_if.blank = 4'($urandom) & 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    ld_if.load = 1'b0;
    run(FR * 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
